// File: rtl/order_book_engine.sv
// Two-sided limit order book: per-side id/price/qty/seq tables updated by a
// three-state accept -> apply -> publish message pipeline with best-price outputs.
module order_book_engine #(
  parameter int DEPTH   = 32,
  parameter int ID_W    = 32,
  parameter int PRICE_W = 32,
  parameter int QTY_W   = 32,
  parameter int SEQ_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_type,
  input  logic                         in_side,
  input  logic [ID_W-1:0]              in_id,
  input  logic [PRICE_W-1:0]           in_price,
  input  logic [QTY_W-1:0]             in_qty,
  output logic                         resp_valid,
  output logic [2:0]                   resp_status,
  output logic [PRICE_W-1:0]           best_bid,
  output logic [PRICE_W-1:0]           best_ask,
  output logic [QTY_W-1:0]             best_bid_qty,
  output logic [QTY_W-1:0]             best_ask_qty,
  output logic                         bid_valid,
  output logic                         ask_valid,
  output logic                         book_upd,
  output logic [$clog2(DEPTH+1)-1:0]   bid_count,
  output logic [$clog2(DEPTH+1)-1:0]   ask_count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [7:0] T_ADD = 8'h41;
  localparam logic [7:0] T_DEL = 8'h44;
  localparam logic [7:0] T_UPD = 8'h55;
  localparam logic [7:0] T_EXE = 8'h45;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_FULL      = 3'd1;
  localparam logic [2:0] ST_DUP_ID    = 3'd2;
  localparam logic [2:0] ST_NOT_FOUND = 3'd3;
  localparam logic [2:0] ST_BAD_TYPE  = 3'd4;
  localparam logic [2:0] ST_ZERO_QTY  = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, PUBLISH = 2'd2} state_t;
  typedef enum logic [2:0] {OP_NONE = 3'd0, OP_ADD = 3'd1, OP_DEL = 3'd2,
                            OP_QTY = 3'd3, OP_REPRICE = 3'd4} op_t;

  state_t               state_r;
  logic [7:0]           msg_type_r;
  logic                 msg_side_r;
  logic [ID_W-1:0]      msg_id_r;
  logic [PRICE_W-1:0]   msg_price_r;
  logic [QTY_W-1:0]     msg_qty_r;
  logic [SEQ_W-1:0]     seq_ctr_r;
  logic [CNT_W-1:0]     cnt_r [2];

  // Tables indexed [side][slot], side 1 = bid, 0 = ask
  logic                 ent_valid_r [2][DEPTH];
  logic [ID_W-1:0]      ent_id_r    [2][DEPTH];
  logic [PRICE_W-1:0]   ent_price_r [2][DEPTH];
  logic [QTY_W-1:0]     ent_qty_r   [2][DEPTH];
  logic [SEQ_W-1:0]     ent_seq_r   [2][DEPTH];

  logic                 hit_s;
  logic [IDX_W-1:0]     hit_idx_s;
  logic [IDX_W-1:0]     free_idx_s;
  logic [PRICE_W-1:0]   hit_price_s;
  logic [QTY_W-1:0]     hit_qty_s;
  logic [2:0]           status_s;
  op_t                  op_s;
  logic [QTY_W-1:0]     new_qty_s;

  logic                 bb_found_s, ba_found_s;
  logic [PRICE_W-1:0]   bb_price_s, ba_price_s;
  logic [QTY_W-1:0]     bb_qty_s, ba_qty_s;
  logic [SEQ_W-1:0]     bb_seq_s, ba_seq_s;

  assign bid_count = cnt_r[1];
  assign ask_count = cnt_r[0];
  assign hit_price_s = ent_price_r[msg_side_r][hit_idx_s];
  assign hit_qty_s   = ent_qty_r[msg_side_r][hit_idx_s];

  // Locate the message id on its side and the lowest-index free slot
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = {IDX_W{1'b0}};
    free_idx_s = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid_r[msg_side_r][i] && (ent_id_r[msg_side_r][i] == msg_id_r)) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_s     = hit_s;
      end
      if (!ent_valid_r[msg_side_r][i]) begin
        free_idx_s = IDX_W'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Decode the held message into a result code and a table operation
  always_comb begin
    status_s  = ST_OK;
    op_s      = OP_NONE;
    new_qty_s = msg_qty_r;
    case (msg_type_r)
      T_ADD: begin
        if (msg_qty_r == {QTY_W{1'b0}})                status_s = ST_ZERO_QTY;
        else if (hit_s)                                status_s = ST_DUP_ID;
        else if (cnt_r[msg_side_r] == CNT_W'(DEPTH))   status_s = ST_FULL;
        else                                           op_s     = OP_ADD;
      end
      T_DEL: begin
        if (!hit_s) status_s = ST_NOT_FOUND;
        else        op_s     = OP_DEL;
      end
      T_UPD: begin
        if (!hit_s)                              status_s = ST_NOT_FOUND;
        else if (msg_qty_r == {QTY_W{1'b0}})     op_s     = OP_DEL;
        else if (msg_price_r != hit_price_s)     op_s     = OP_REPRICE;
        else                                     op_s     = OP_QTY;
      end
      T_EXE: begin
        if (!hit_s)                              status_s = ST_NOT_FOUND;
        else if (msg_qty_r == {QTY_W{1'b0}})     status_s = ST_ZERO_QTY;
        else if (msg_qty_r < hit_qty_s) begin
          op_s      = OP_QTY;
          new_qty_s = hit_qty_s - msg_qty_r;
        end else begin
          op_s      = OP_DEL;
        end
      end
      default: status_s = ST_BAD_TYPE;
    endcase
  end

  // Best-price scan: highest bid / lowest ask, earlier seq wins a price tie
  always_comb begin
    bb_found_s = 1'b0;
    bb_price_s = {PRICE_W{1'b0}};
    bb_qty_s   = {QTY_W{1'b0}};
    bb_seq_s   = {SEQ_W{1'b0}};
    ba_found_s = 1'b0;
    ba_price_s = {PRICE_W{1'b1}};
    ba_qty_s   = {QTY_W{1'b0}};
    ba_seq_s   = {SEQ_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid_r[1][i] && (!bb_found_s || (ent_price_r[1][i] > bb_price_s) ||
          ((ent_price_r[1][i] == bb_price_s) && (ent_seq_r[1][i] < bb_seq_s)))) begin
        bb_found_s = 1'b1;
        bb_price_s = ent_price_r[1][i];
        bb_qty_s   = ent_qty_r[1][i];
        bb_seq_s   = ent_seq_r[1][i];
      end else begin
        bb_found_s = bb_found_s;
      end
      if (ent_valid_r[0][i] && (!ba_found_s || (ent_price_r[0][i] < ba_price_s) ||
          ((ent_price_r[0][i] == ba_price_s) && (ent_seq_r[0][i] < ba_seq_s)))) begin
        ba_found_s = 1'b1;
        ba_price_s = ent_price_r[0][i];
        ba_qty_s   = ent_qty_r[0][i];
        ba_seq_s   = ent_seq_r[0][i];
      end else begin
        ba_found_s = ba_found_s;
      end
    end
  end

  // Message FSM, table writes and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      in_ready     <= 1'b1;
      resp_valid   <= 1'b0;
      resp_status  <= ST_OK;
      book_upd     <= 1'b0;
      best_bid     <= {PRICE_W{1'b0}};
      best_bid_qty <= {QTY_W{1'b0}};
      bid_valid    <= 1'b0;
      best_ask     <= {PRICE_W{1'b1}};
      best_ask_qty <= {QTY_W{1'b0}};
      ask_valid    <= 1'b0;
      msg_type_r   <= 8'h00;
      msg_side_r   <= 1'b0;
      msg_id_r     <= {ID_W{1'b0}};
      msg_price_r  <= {PRICE_W{1'b0}};
      msg_qty_r    <= {QTY_W{1'b0}};
      seq_ctr_r    <= {SEQ_W{1'b0}};
      for (int s = 0; s < 2; s++) begin
        cnt_r[s] <= {CNT_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
          ent_valid_r[s][i] <= 1'b0;
          ent_id_r[s][i]    <= {ID_W{1'b0}};
          ent_price_r[s][i] <= {PRICE_W{1'b0}};
          ent_qty_r[s][i]   <= {QTY_W{1'b0}};
          ent_seq_r[s][i]   <= {SEQ_W{1'b0}};
        end
      end
    end else begin
      resp_valid <= 1'b0;
      book_upd   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            msg_type_r  <= in_type;
            msg_side_r  <= in_side;
            msg_id_r    <= in_id;
            msg_price_r <= in_price;
            msg_qty_r   <= in_qty;
            in_ready    <= 1'b0;
            state_r     <= APPLY;
          end
        end
        APPLY: begin
          resp_valid  <= 1'b1;
          resp_status <= status_s;
          state_r     <= PUBLISH;
          case (op_s)
            OP_ADD: begin
              ent_valid_r[msg_side_r][free_idx_s] <= 1'b1;
              ent_id_r[msg_side_r][free_idx_s]    <= msg_id_r;
              ent_price_r[msg_side_r][free_idx_s] <= msg_price_r;
              ent_qty_r[msg_side_r][free_idx_s]   <= msg_qty_r;
              ent_seq_r[msg_side_r][free_idx_s]   <= seq_ctr_r;
              seq_ctr_r                           <= seq_ctr_r + SEQ_W'(1);
              cnt_r[msg_side_r]                   <= cnt_r[msg_side_r] + CNT_W'(1);
            end
            OP_DEL: begin
              ent_valid_r[msg_side_r][hit_idx_s] <= 1'b0;
              cnt_r[msg_side_r]                  <= cnt_r[msg_side_r] - CNT_W'(1);
            end
            OP_QTY: begin
              ent_qty_r[msg_side_r][hit_idx_s] <= new_qty_s;
            end
            OP_REPRICE: begin
              ent_price_r[msg_side_r][hit_idx_s] <= msg_price_r;
              ent_qty_r[msg_side_r][hit_idx_s]   <= msg_qty_r;
              ent_seq_r[msg_side_r][hit_idx_s]   <= seq_ctr_r;
              seq_ctr_r                          <= seq_ctr_r + SEQ_W'(1);
            end
            default: begin
            end
          endcase
        end
        PUBLISH: begin
          best_bid     <= bb_price_s;
          best_bid_qty <= bb_qty_s;
          bid_valid    <= bb_found_s;
          best_ask     <= ba_price_s;
          best_ask_qty <= ba_qty_s;
          ask_valid    <= ba_found_s;
          book_upd     <= 1'b1;
          in_ready     <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state_r  <= IDLE;
        end
      endcase
    end
  end
endmodule
